// File: rtl/interdevice_tx_arbiter_pkg.sv
// types: flit and tx-source types shared by the interdevice transmit arbiter and its priority selector.
package types;
    localparam int FLIT_W = 32;
    typedef logic [FLIT_W-1:0] flit_t;
    typedef enum logic [1:0] {
        TX_SRC_NONE   = 2'd0,
        TX_SRC_ACK    = 2'd1,
        TX_SRC_RESEND = 2'd2,
        TX_SRC_NORMAL = 2'd3
    } tx_src_t;
    // Grant vectors are ordered {normal, resend, ack}.
    function automatic tx_src_t src_of(input logic [2:0] gnt);
        return gnt[0] ? TX_SRC_ACK : gnt[1] ? TX_SRC_RESEND : gnt[2] ? TX_SRC_NORMAL : TX_SRC_NONE;
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return c + {31'd0, en && !(&c)};
    endfunction
endpackage

// File: rtl/interdevice_tx_arbiter_priority_select.sv
// tx_priority_select: one-hot winner among {normal, resend, ack}; starved sources beat ack, rr_ptr breaks resend/normal ties.
module tx_priority_select (
    input  logic [2:0] valid_i,
    input  logic [1:0] starved_i,
    input  logic       rr_ptr_i,
    output logic [2:0] grant_o
);
    logic [1:0] st;
    logic [1:0] pair;
    logic [1:0] pick;
    logic       use_ack;
    always_comb begin
        st      = starved_i & valid_i[2:1];
        use_ack = !(|st) && valid_i[0];
        pair    = |st ? st : valid_i[2:1];
        pick    = &pair ? (rr_ptr_i ? 2'b10 : 2'b01) : pair;
        grant_o = use_ack ? 3'b001 : {pick, 1'b0};
    end
endmodule

// File: rtl/interdevice_tx_arbiter.sv
// interdevice_tx_arbiter: 3-source arbiter (ack/resend/normal) with starvation override feeding one registered tx slot.
// Optional saturating grant/starvation statistics when TX_ARB_STATS_EN is defined.
module interdevice_tx_arbiter
    import types::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic    nocclk,
    input  logic    rst_n,
    input  flit_t   ack_flit,
    input  logic    ack_valid,
    output logic    ack_ready,
    input  flit_t   resend_flit,
    input  logic    resend_valid,
    output logic    resend_ready,
    input  flit_t   normal_flit,
    input  logic    normal_valid,
    output logic    normal_ready,
    output flit_t   interdevice_tx_flit,
    output logic    interdevice_tx_valid,
    input  logic    interdevice_tx_ready,
    output tx_src_t grant_src
`ifdef TX_ARB_STATS_EN
    ,
    output logic [31:0] stat_ack_cnt,
    output logic [31:0] stat_resend_cnt,
    output logic [31:0] stat_normal_cnt,
    output logic [31:0] stat_starve_cnt
`endif
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

    logic [CW-1:0] rs_wait_q, rs_wait_d, nm_wait_q, nm_wait_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          valid_q, valid_d;
    tx_src_t       src_q, src_d;
    flit_t         flit_q, flit_d;
    logic          open_slot;
    logic [1:0]    starved;
    logic [2:0]    gnt, rdy;

    assign starved   = {normal_valid && nm_wait_q == WMAX, resend_valid && rs_wait_q == WMAX};
    assign open_slot = !valid_q || interdevice_tx_ready;

    tx_priority_select u_sel (
        .valid_i   ({normal_valid, resend_valid, ack_valid}),
        .starved_i (starved),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (gnt)
    );

    // Readies are held low during reset even though the empty slot looks open.
    assign rdy          = (open_slot && rst_n) ? gnt : 3'b000;
    assign ack_ready    = rdy[0];
    assign resend_ready = rdy[1];
    assign normal_ready = rdy[2];

    always_comb begin
        valid_d   = open_slot ? |rdy : valid_q;
        src_d     = open_slot ? src_of(rdy) : src_q;
        flit_d    = rdy[0] ? ack_flit : rdy[1] ? resend_flit : rdy[2] ? normal_flit : flit_q;
        rr_ptr_d  = (rdy[1] || rdy[2]) ? !rr_ptr_q : rr_ptr_q;
        rs_wait_d = (!resend_valid || rdy[1]) ? '0 : (rs_wait_q == WMAX) ? rs_wait_q : rs_wait_q + 1'b1;
        nm_wait_d = (!normal_valid || rdy[2]) ? '0 : (nm_wait_q == WMAX) ? nm_wait_q : nm_wait_q + 1'b1;
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            src_q     <= TX_SRC_NONE;
            rr_ptr_q  <= 1'b0;
            rs_wait_q <= '0;
            nm_wait_q <= '0;
        end else begin
            valid_q   <= valid_d;
            src_q     <= src_d;
            rr_ptr_q  <= rr_ptr_d;
            rs_wait_q <= rs_wait_d;
            nm_wait_q <= nm_wait_d;
        end
    end

    always_ff @(posedge nocclk) begin
        flit_q <= flit_d;
    end

    assign interdevice_tx_flit  = flit_q;
    assign interdevice_tx_valid = valid_q;
    assign grant_src            = src_q;

`ifdef TX_ARB_STATS_EN
    logic [31:0] ack_cnt_q, rs_cnt_q, nm_cnt_q, starve_cnt_q;
    logic        starve_hit;
    assign starve_hit = |(rdy[2:1] & starved);
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt_q    <= '0;
            rs_cnt_q     <= '0;
            nm_cnt_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            ack_cnt_q    <= sat_inc(ack_cnt_q, rdy[0]);
            rs_cnt_q     <= sat_inc(rs_cnt_q, rdy[1]);
            nm_cnt_q     <= sat_inc(nm_cnt_q, rdy[2]);
            starve_cnt_q <= sat_inc(starve_cnt_q, starve_hit);
        end
    end
    assign stat_ack_cnt    = ack_cnt_q;
    assign stat_resend_cnt = rs_cnt_q;
    assign stat_normal_cnt = nm_cnt_q;
    assign stat_starve_cnt = starve_cnt_q;
`endif
endmodule
